// File: rtl/pspin_ingress_dma_ctrl.sv
// rtl/pspin_ingress_dma_ctrl.sv - per-frame ingress DMA sequencer: length -> slot alloc -> write descriptor, tag table.
// Optional PSPIN_INGRESS_CTRL_STATS_EN adds saturating frame/error/clamp counters.
module pspin_ingress_dma_ctrl #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH       = 20,
  parameter int TAG_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int INGRESS_DMA_MTU = 1500
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [LEN_WIDTH-1:0]               s_len_len,
  input  logic                               s_len_valid,
  output logic                               s_len_ready,
  output logic [LEN_WIDTH-1:0]               alloc_req_len,
  output logic                               alloc_req_valid,
  input  logic                               alloc_req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]          alloc_resp_addr,
  input  logic                               alloc_resp_valid,
  output logic [AXI_ADDR_WIDTH-1:0]          write_desc_addr,
  output logic [LEN_WIDTH-1:0]               write_desc_len,
  output logic [TAG_WIDTH-1:0]               write_desc_tag,
  output logic                               write_desc_valid,
  input  logic                               write_desc_ready,
  input  logic [TAG_WIDTH-1:0]               status_tag,
  input  logic [3:0]                         status_error,
  input  logic                               status_valid,
  output logic [AXI_ADDR_WIDTH-1:0]          free_addr,
  output logic [LEN_WIDTH-1:0]               free_len,
  output logic                               free_valid,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_bad_status
`ifdef PSPIN_INGRESS_CTRL_STATS_EN
  ,
  output logic [31:0]                        stat_frames,
  output logic [31:0]                        stat_dma_err,
  output logic [31:0]                        stat_clamped
`endif
);

  localparam int IDX_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_ADDR, S_ISSUE} state_t;

  state_t                    state, state_nxt;
  logic [TAG_WIDTH-1:0]      seq;
  logic [MAX_OUTSTANDING-1:0] tbl_valid;
  logic [AXI_ADDR_WIDTH-1:0] tbl_addr [MAX_OUTSTANDING];
  logic [LEN_WIDTH-1:0]      tbl_len  [MAX_OUTSTANDING];
  logic [TAG_WIDTH-1:0]      tbl_tag  [MAX_OUTSTANDING];

  logic [IDX_W-1:0]          free_idx;
  logic [IDX_W-1:0]          st_idx;
  logic [IDX_W-1:0]          issue_idx;
  logic                      st_match;
  logic                      len_hs;
  logic                      issue_hs;
  logic                      len_clamped;
  logic [LEN_WIDTH-1:0]      len_eff;
  logic [TAG_WIDTH-1:0]      new_tag;
  logic [CNT_W-1:0]          outstanding_nxt;

  assign len_hs    = s_len_valid && s_len_ready;
  assign issue_hs  = write_desc_valid && write_desc_ready;
  assign st_idx    = status_tag[IDX_W-1:0];
  assign issue_idx = write_desc_tag[IDX_W-1:0];
  assign st_match  = status_valid && tbl_valid[st_idx] && (tbl_tag[st_idx] == status_tag);
  assign new_tag   = (seq << IDX_W) | TAG_WIDTH'(free_idx);

  always_comb begin
    free_idx = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!tbl_valid[i]) free_idx = IDX_W'(i);
    end
  end

  // Zero-length frames still need a 1-byte slot; oversize frames are truncated by the DMA.
  always_comb begin
    len_clamped = 1'b1;
    if (s_len_len == '0)
      len_eff = LEN_WIDTH'(1);
    else if (s_len_len > LEN_WIDTH'(INGRESS_DMA_MTU))
      len_eff = LEN_WIDTH'(INGRESS_DMA_MTU);
    else begin
      len_eff     = s_len_len;
      len_clamped = 1'b0;
    end
  end

  always_comb begin
    case ({issue_hs, st_match})
      2'b10:   outstanding_nxt = outstanding + CNT_W'(1);
      2'b01:   outstanding_nxt = outstanding - CNT_W'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (len_hs)           state_nxt = S_REQ;
      S_REQ:       if (alloc_req_ready)  state_nxt = S_WAIT_ADDR;
      S_WAIT_ADDR: if (alloc_resp_valid) state_nxt = S_ISSUE;
      S_ISSUE:     if (write_desc_ready) state_nxt = S_IDLE;
      default:                           state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= S_IDLE;
      seq              <= '0;
      tbl_valid        <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tbl_addr[i] <= '0;
        tbl_len[i]  <= '0;
        tbl_tag[i]  <= '0;
      end
      s_len_ready      <= 1'b0;
      alloc_req_len    <= '0;
      alloc_req_valid  <= 1'b0;
      write_desc_addr  <= '0;
      write_desc_len   <= '0;
      write_desc_tag   <= '0;
      write_desc_valid <= 1'b0;
      free_addr        <= '0;
      free_len         <= '0;
      free_valid       <= 1'b0;
      outstanding      <= '0;
      err_bad_status   <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      s_len_ready <= (state_nxt == S_IDLE) && (outstanding_nxt < CNT_W'(MAX_OUTSTANDING));

      if (len_hs) begin
        alloc_req_len   <= len_eff;
        alloc_req_valid <= 1'b1;
      end
      if (state == S_REQ && alloc_req_ready) alloc_req_valid <= 1'b0;

      // Slot chosen on entry to ISSUE so the tag stays stable while valid.
      if (state == S_WAIT_ADDR && alloc_resp_valid) begin
        write_desc_addr  <= alloc_resp_addr;
        write_desc_len   <= alloc_req_len;
        write_desc_tag   <= new_tag;
        write_desc_valid <= 1'b1;
      end
      if (issue_hs) begin
        write_desc_valid     <= 1'b0;
        tbl_valid[issue_idx] <= 1'b1;
        tbl_addr[issue_idx]  <= write_desc_addr;
        tbl_len[issue_idx]   <= write_desc_len;
        tbl_tag[issue_idx]   <= write_desc_tag;
        seq                  <= seq + TAG_WIDTH'(1);
      end

      free_valid <= st_match && (status_error != 4'd0);
      if (st_match) begin
        tbl_valid[st_idx] <= 1'b0;
        free_addr         <= tbl_addr[st_idx];
        free_len          <= tbl_len[st_idx];
      end
      if (status_valid && !st_match) err_bad_status <= 1'b1;
    end
  end

`ifdef PSPIN_INGRESS_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_frames  <= '0;
      stat_dma_err <= '0;
      stat_clamped <= '0;
    end else begin
      if (issue_hs && stat_frames != 32'hFFFF_FFFF) stat_frames <= stat_frames + 32'd1;
      if (st_match && status_error != 4'd0 && stat_dma_err != 32'hFFFF_FFFF)
        stat_dma_err <= stat_dma_err + 32'd1;
      if (len_hs && len_clamped && stat_clamped != 32'hFFFF_FFFF)
        stat_clamped <= stat_clamped + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pspin_ingress_dma_ctrl.sv
// tb/tb_pspin_ingress_dma_ctrl.sv - randomized bench with in-flight-set reference model for pspin_ingress_dma_ctrl.
module tb_pspin_ingress_dma_ctrl;
  localparam int AW  = 32;
  localparam int LW  = 20;
  localparam int TW  = 8;
  localparam int MO  = 4;
  localparam int MTU = 1500;
  localparam int IW  = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [LW-1:0] s_len_len = '0;
  logic          s_len_valid = 1'b0;
  logic          s_len_ready;
  logic [LW-1:0] alloc_req_len;
  logic          alloc_req_valid;
  logic          alloc_req_ready = 1'b0;
  logic [AW-1:0] alloc_resp_addr = '0;
  logic          alloc_resp_valid = 1'b0;
  logic [AW-1:0] write_desc_addr;
  logic [LW-1:0] write_desc_len;
  logic [TW-1:0] write_desc_tag;
  logic          write_desc_valid;
  logic          write_desc_ready = 1'b0;
  logic [TW-1:0] status_tag = '0;
  logic [3:0]    status_error = '0;
  logic          status_valid = 1'b0;
  logic [AW-1:0] free_addr;
  logic [LW-1:0] free_len;
  logic          free_valid;
  logic [IW:0]   outstanding;
  logic          err_bad_status;

  always #5 clk = ~clk;

  pspin_ingress_dma_ctrl #(
    .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW),
    .MAX_OUTSTANDING(MO), .INGRESS_DMA_MTU(MTU)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_len_len(s_len_len), .s_len_valid(s_len_valid), .s_len_ready(s_len_ready),
    .alloc_req_len(alloc_req_len), .alloc_req_valid(alloc_req_valid), .alloc_req_ready(alloc_req_ready),
    .alloc_resp_addr(alloc_resp_addr), .alloc_resp_valid(alloc_resp_valid),
    .write_desc_addr(write_desc_addr), .write_desc_len(write_desc_len), .write_desc_tag(write_desc_tag),
    .write_desc_valid(write_desc_valid), .write_desc_ready(write_desc_ready),
    .status_tag(status_tag), .status_error(status_error), .status_valid(status_valid),
    .free_addr(free_addr), .free_len(free_len), .free_valid(free_valid),
    .outstanding(outstanding), .err_bad_status(err_bad_status)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: set of in-flight descriptors keyed by table slot.
  bit            m_valid [MO];
  logic [TW-1:0] m_tag   [MO];
  logic [AW-1:0] m_addr  [MO];
  logic [LW-1:0] m_len   [MO];
  int            m_count = 0;
  int            m_seq   = 0;
  bit            m_err   = 0;

  task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] exp_len(input int unsigned l);
    if (l == 0) return LW'(1);
    if (l > MTU) return LW'(MTU);
    return LW'(l);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < MO; i++) m_valid[i] = 0;
    m_count = 0;
    m_seq   = 0;
    m_err   = 0;
  endtask

  task automatic send_frame(input int unsigned len, input logic [AW-1:0] addr,
                            input int a_dly, input int r_dly, input int d_dly, input bit stop_at_issue);
    int slot;
    logic [TW-1:0] etag;
    for (int i = 0; i < 10 && !s_len_ready; i++) tick();
    check_val("len_ready_avail", s_len_ready, 1);
    s_len_valid = 1'b1;
    s_len_len   = LW'(len);
    tick();
    s_len_valid = 1'b0;
    s_len_len   = LW'($urandom);
    check_val("alloc_req_valid", alloc_req_valid, 1);
    check_val("alloc_req_len", alloc_req_len, exp_len(len));
    check_val("len_ready_busy", s_len_ready, 0);
    for (int i = 0; i < a_dly; i++) begin
      if (i == 0) begin
        alloc_resp_valid = 1'b1;
        alloc_resp_addr  = ~addr;
      end
      tick();
      alloc_resp_valid = 1'b0;
    end
    if (a_dly > 0) check_val("alloc_req_hold", alloc_req_valid, 1);
    alloc_req_ready = 1'b1;
    tick();
    alloc_req_ready = 1'b0;
    check_val("alloc_req_drop", alloc_req_valid, 0);
    for (int i = 0; i < r_dly; i++) tick();
    alloc_resp_valid = 1'b1;
    alloc_resp_addr  = addr;
    tick();
    alloc_resp_valid = 1'b0;
    slot = -1;
    for (int i = 0; i < MO; i++) if (!m_valid[i] && slot < 0) slot = i;
    etag = TW'((m_seq << IW) | slot);
    check_val("desc_valid", write_desc_valid, 1);
    check_val("desc_addr", write_desc_addr, addr);
    check_val("desc_len", write_desc_len, exp_len(len));
    check_val("desc_tag", write_desc_tag, etag);
    if (stop_at_issue) return;
    for (int i = 0; i < d_dly; i++) tick();
    if (d_dly > 0) check_val("desc_tag_stable", write_desc_tag, etag);
    write_desc_ready = 1'b1;
    tick();
    write_desc_ready = 1'b0;
    m_valid[slot] = 1;
    m_tag[slot]   = etag;
    m_addr[slot]  = addr;
    m_len[slot]   = exp_len(len);
    m_count++;
    m_seq++;
    check_val("desc_drop", write_desc_valid, 0);
    check_val("outstanding_issue", outstanding, m_count);
  endtask

  task automatic complete(input logic [TW-1:0] tag, input logic [3:0] err);
    int hit;
    logic [AW-1:0] ea;
    logic [LW-1:0] el;
    bit efree;
    hit = -1;
    for (int i = 0; i < MO; i++) if (m_valid[i] && m_tag[i] == tag) hit = i;
    status_valid = 1'b1;
    status_tag   = tag;
    status_error = err;
    tick();
    status_valid = 1'b0;
    efree = 0;
    ea = '0;
    el = '0;
    if (hit >= 0) begin
      ea = m_addr[hit];
      el = m_len[hit];
      efree = (err != 0);
      m_valid[hit] = 0;
      m_count--;
    end else begin
      m_err = 1;
    end
    check_val("free_valid", free_valid, efree);
    if (efree) begin
      check_val("free_addr", free_addr, ea);
      check_val("free_len", free_len, el);
    end
    check_val("outstanding_status", outstanding, m_count);
    check_val("err_bad_status", err_bad_status, m_err);
    tick();
    check_val("free_pulse_end", free_valid, 0);
  endtask

  task automatic complete_random();
    int s;
    logic [3:0] e;
    s = $urandom_range(0, MO - 1);
    while (!m_valid[s]) s = (s + 1) % MO;
    e = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    complete(m_tag[s], e);
  endtask

  task automatic drain();
    while (m_count > 0) complete_random();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned len;
    int r;
    logic [31:0] rnd;
    model_clear();
    repeat (3) tick();
    check_val("rst_len_ready", s_len_ready, 0);
    check_val("rst_alloc_valid", alloc_req_valid, 0);
    check_val("rst_desc_valid", write_desc_valid, 0);
    check_val("rst_free_valid", free_valid, 0);
    check_val("rst_outstanding", outstanding, 0);
    check_val("rst_err", err_bad_status, 0);
    rstn = 1'b1;
    tick();

    send_frame(64, 32'h1000, 0, 0, 0, 0);
    complete(m_tag[0], 4'd0);

    for (int i = 0; i < MO; i++) send_frame(100 + i, 32'h4000 + 32'(i * 'h100), 0, 0, 0, 0);
    s_len_valid = 1'b1;
    s_len_len   = LW'(555);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("full_len_ready", s_len_ready, 0);
      check_val("full_no_alloc", alloc_req_valid, 0);
    end
    s_len_valid = 1'b0;
    complete(m_tag[2], 4'd0);
    send_frame(555, 32'h5000, 0, 0, 0, 0);
    drain();

    send_frame(128, 32'h2000, 1, 1, 1, 0);
    complete(m_tag[0], 4'd2);

    send_frame(0, 32'h3000, 0, 0, 0, 0);
    send_frame(9000, 32'h3100, 0, 0, 0, 0);
    drain();

    complete(8'h03, 4'd0);
    tick();
    check_val("err_sticky", err_bad_status, 1);

    for (int it = 0; it < 60; it++) begin
      if (m_count > 0 && (m_count == MO || $urandom_range(0, 1) == 1)) complete_random();
      if ($urandom_range(0, 9) == 0) begin
        rnd = $urandom;
        complete(rnd[TW-1:0], rnd[11:8]);
      end
      r = $urandom_range(0, 7);
      case (r)
        0:       len = 0;
        1:       len = MTU;
        2:       len = MTU + 1;
        3:       len = $urandom_range(MTU + 2, (1 << LW) - 1);
        default: len = $urandom_range(1, MTU);
      endcase
      send_frame(len, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
    drain();

    send_frame(77, 32'h7000, 0, 0, 0, 0);
    send_frame(88, 32'h8000, 0, 0, 0, 1);
    rstn = 1'b0;
    #1;
    check_val("rst_issue_desc_valid", write_desc_valid, 0);
    check_val("rst_issue_outstanding", outstanding, 0);
    check_val("rst_issue_err", err_bad_status, 0);
    model_clear();
    tick();
    rstn = 1'b1;
    tick();
    send_frame(200, 32'h9000, 0, 0, 0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
